// File: rtl/io_xbar_unflip_bus_if.sv
// Handshake bundle for the bus-invert receive decoder: the flit input side and the decoded output side.
interface io_xbar_unflip_bus_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_flip;
  logic             in_val;
  logic             in_rdy;
  logic [WIDTH-1:0] out_data;
  logic             out_val;
  logic             out_rdy;

  modport slave (
    input  in_data, in_flip, in_val, out_rdy,
    output in_rdy, out_data, out_val
  );

  modport master (
    output in_data, in_flip, in_val, out_rdy,
    input  in_rdy, out_data, out_val
  );
endinterface

// File: rtl/io_xbar_unflip_bus.sv
// Bus-invert receive decoder: restores flit polarity into a 2-entry skid FIFO,
// keeps a saturating flip count and a link-idle watchdog.
module io_xbar_unflip_bus #(
  parameter int WIDTH = 8,
  parameter int BHC   = 10,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  io_xbar_unflip_bus_if.slave  bus,
  input  logic                 clr_stats,
  output logic [CNT_W-1:0]     flip_cnt,
  output logic                 link_idle
);
  localparam int IW = $clog2(BHC + 1);

  logic [1:0]       cnt_q, cnt_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic [CNT_W-1:0] flip_cnt_q, flip_cnt_d;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic             link_idle_q, link_idle_d;
  logic             accept, release_w;

  // Ready comes only from registered occupancy, so out_rdy never reaches in_rdy combinationally.
  assign bus.in_rdy   = (cnt_q != 2'd2);
  assign bus.out_val  = (cnt_q != 2'd0);
  assign bus.out_data = mem_q[rd_ptr_q];
  assign flip_cnt     = flip_cnt_q;
  assign link_idle    = link_idle_q;

  assign accept    = bus.in_val & bus.in_rdy;
  assign release_w = bus.out_val & bus.out_rdy;

  always_comb begin
    cnt_d       = cnt_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    mem_d       = mem_q;
    flip_cnt_d  = flip_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    link_idle_d = 1'b0;

    if (accept) begin
      mem_d[wr_ptr_q] = bus.in_flip ? ~bus.in_data : bus.in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (release_w) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (accept && !release_w) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!accept && release_w) begin
      cnt_d = cnt_q - 2'd1;
    end

    if (clr_stats) begin
      flip_cnt_d = '0;
    end else if (accept && bus.in_flip && (flip_cnt_q != {CNT_W{1'b1}})) begin
      flip_cnt_d = flip_cnt_q + CNT_W'(1);
    end

    // link_idle follows the saturated count one cycle later; an accept clears it immediately.
    if (accept) begin
      idle_cnt_d = '0;
    end else begin
      if (idle_cnt_q != IW'(BHC)) begin
        idle_cnt_d = idle_cnt_q + IW'(1);
      end
      link_idle_d = (idle_cnt_q == IW'(BHC));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      flip_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      link_idle_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      mem_q       <= mem_d;
      flip_cnt_q  <= flip_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      link_idle_q <= link_idle_d;
    end
  end
endmodule

// File: tb/tb_io_xbar_unflip_bus.sv
// Randomized and directed checks of io_xbar_unflip_bus against a queue-based reference model.
module tb_io_xbar_unflip_bus;
  localparam int WIDTH = 8;
  localparam int BHC   = 10;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             clr_stats;
  logic [CNT_W-1:0] flip_cnt;
  logic             link_idle;

  io_xbar_unflip_bus_if #(.WIDTH(WIDTH)) bus ();

  io_xbar_unflip_bus #(.WIDTH(WIDTH), .BHC(BHC), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_stats (clr_stats),
    .flip_cnt  (flip_cnt),
    .link_idle (link_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [WIDTH-1:0] q[$];
  int  m_fcnt;
  int  m_streak;
  bit  m_link;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fcnt   = 0;
    m_streak = 0;
    m_link   = 1'b0;
  endtask

  // Check current outputs, drive one cycle of inputs, advance to just after the edge, update model.
  task automatic cyc(input bit v, input logic [WIDTH-1:0] d, input bit f, input bit r, input bit c);
    bit erdy, eoval, acc, rel;
    erdy  = (q.size() < 2);
    eoval = (q.size() != 0);
    chk("in_rdy", {31'd0, bus.in_rdy}, {31'd0, erdy});
    chk("out_val", {31'd0, bus.out_val}, {31'd0, eoval});
    if (eoval) chk("out_data", {24'd0, bus.out_data}, {24'd0, q[0]});
    chk("flip_cnt", {28'd0, flip_cnt}, m_fcnt);
    chk("link_idle", {31'd0, link_idle}, {31'd0, m_link});
    bus.in_val  = v;
    bus.in_data = d;
    bus.in_flip = f;
    bus.out_rdy = r;
    clr_stats   = c;
    acc = v && erdy;
    rel = eoval && r;
    @(posedge clk);
    #1;
    if (rel) void'(q.pop_front());
    if (acc) q.push_back(f ? ~d : d);
    if (c) m_fcnt = 0;
    else if (acc && f && m_fcnt < CMAX) m_fcnt++;
    if (acc) begin
      m_link   = 1'b0;
      m_streak = 0;
    end else begin
      m_link = (m_streak >= BHC);
      m_streak++;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.in_val  = 1'b0;
    bus.in_data = '0;
    bus.in_flip = 1'b0;
    bus.out_rdy = 1'b0;
    clr_stats   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    rst_n = 1'b1;

    // idle watchdog from reset: rises after BHC+1 edges with no accept
    for (int i = 0; i < 12; i++) cyc(0, 8'h00, 0, 1, 0);
    chk("idle_high", {31'd0, link_idle}, 32'd1);
    cyc(1, 8'hA5, 1, 0, 0);
    chk("idle_cleared", {31'd0, link_idle}, 32'd0);
    chk("single_val", {31'd0, bus.out_val}, 32'd1);
    chk("single_data", {24'd0, bus.out_data}, 32'h5A);
    chk("single_fcnt", {28'd0, flip_cnt}, 32'd1);
    cyc(0, 8'h00, 0, 1, 0);

    // backpressure: third flit held until downstream drains
    cyc(1, 8'h01, 0, 0, 0);
    cyc(1, 8'h02, 0, 0, 0);
    chk("full_rdy", {31'd0, bus.in_rdy}, 32'd0);
    cyc(1, 8'h03, 0, 0, 0);
    cyc(1, 8'h03, 0, 0, 0);
    cyc(1, 8'h03, 0, 1, 0);
    cyc(0, 8'h00, 0, 1, 0);
    cyc(0, 8'h00, 0, 1, 0);
    cyc(0, 8'h00, 0, 1, 0);

    // streaming at occupancy 1
    cyc(1, 8'h55, 0, 1, 0);
    cyc(1, 8'hFF, 1, 1, 0);
    cyc(1, 8'h00, 0, 1, 0);
    cyc(1, 8'h0F, 1, 1, 0);
    chk("stream_data", {24'd0, bus.out_data}, 32'hF0);
    cyc(0, 8'h00, 0, 1, 0);

    // saturation, then clear overriding a same-cycle flipped accept
    cyc(0, 8'h00, 0, 1, 1);
    for (int i = 0; i < 16; i++) cyc(1, i[7:0], 1, 1, 0);
    chk("sat_fcnt", {28'd0, flip_cnt}, CMAX);
    cyc(1, 8'h77, 1, 1, 1);
    chk("clr_fcnt", {28'd0, flip_cnt}, 32'd0);
    cyc(0, 8'h00, 0, 1, 0);
    cyc(0, 8'h00, 0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 31) == 0));
      if ((i % 400) == 399) begin
        for (int k = 0; k < 14; k++) cyc(0, 8'h00, 0, 1, 0);
      end
    end

    // async reset with a full FIFO and flip_cnt=7
    cyc(0, 8'h00, 0, 1, 1);
    cyc(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'hC3, 1, 1, 0);
    cyc(0, 8'h00, 0, 1, 0);
    cyc(1, 8'h11, 1, 0, 0);
    cyc(1, 8'h22, 1, 0, 0);
    chk("pre_rst_fcnt", {28'd0, flip_cnt}, 32'd7);
    chk("pre_rst_rdy", {31'd0, bus.in_rdy}, 32'd0);
    bus.in_val = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_val", {31'd0, bus.out_val}, 32'd0);
    chk("arst_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
    chk("arst_fcnt", {28'd0, flip_cnt}, 32'd0);
    chk("arst_idle", {31'd0, link_idle}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 8'h3C, 0, 1, 0);
    cyc(0, 8'h00, 0, 1, 0);
    cyc(0, 8'h00, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
